signed_sar_search: RTL and testbench

SIGNED_SAR_SEARCH -- requirements
Module: signed_sar_search

---
 rtl/signed_sar_search.sv | 115 +++++++++++
 tb/tb_signed_sar_search.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/signed_sar_search.sv
// Successive-approximation search for a signed value against an external comparator.
// Trials are generated from an offset-binary code, one bit resolved per accepted response.
`timescale 1ns/1ps
module signed_sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] trial,
    output logic             trial_valid,
    input  logic             cmp_valid,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exact
);

    localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                   state, state_nxt;
    logic [WIDTH-1:0]         c, c_nxt;
    logic [KW-1:0]            k, k_nxt;
    logic [KW-1:0]            k_dec;
    logic signed [WIDTH-1:0]  result_q, result_nxt;
    logic                     exact_q, exact_nxt;
    logic                     hit_eq;

    // Offset binary to two's complement is a flip of the top bit.
    function automatic logic signed [WIDTH-1:0] to_signed(input logic [WIDTH-1:0] code);
        return $signed({~code[WIDTH-1], code[WIDTH-2:0]});
    endfunction

    assign trial       = to_signed(c);
    assign trial_valid = (state == DRIVE);
    assign busy        = (state == DRIVE);
    assign done        = (state == DONE);
    assign result      = result_q;
    assign exact       = exact_q;
    assign k_dec       = k - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            c        <= MID;
            k        <= KW'(WIDTH-1);
            result_q <= '0;
            exact_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            c        <= c_nxt;
            k        <= k_nxt;
            result_q <= result_nxt;
            exact_q  <= exact_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        c_nxt      = c;
        k_nxt      = k;
        result_nxt = result_q;
        exact_nxt  = exact_q;
        hit_eq     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRIVE;
                    c_nxt     = MID;
                    k_nxt     = KW'(WIDTH-1);
                end
            end
            DRIVE: begin
                if (cmp_valid) begin
                    // eq beats gt beats lt; no flag at all resolves as lt.
                    casez ({cmp_eq, cmp_gt, cmp_lt})
                        3'b1??:  hit_eq   = 1'b1;
                        3'b01?:  c_nxt[k] = 1'b1;
                        default: c_nxt[k] = 1'b0;
                    endcase
                    if (hit_eq) begin
                        result_nxt = to_signed(c);
                        exact_nxt  = 1'b1;
                        state_nxt  = DONE;
                    end else if (k == '0) begin
                        // Saturates naturally: all-ones code is the max, all-zeros the min.
                        result_nxt = to_signed(c_nxt);
                        exact_nxt  = 1'b0;
                        state_nxt  = DONE;
                    end else begin
                        c_nxt[k_dec] = 1'b1;
                        k_nxt        = k_dec;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_signed_sar_search.sv
// Directed bench for signed_sar_search (WIDTH=4) with a delayed comparator model.
`timescale 1ns/1ps
module tb_signed_sar_search;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         cmp_valid = 1'b0;
    logic         cmp_gt = 1'b0;
    logic         cmp_lt = 1'b0;
    logic         cmp_eq = 1'b0;
    logic [W-1:0] trial;
    logic [W-1:0] result;
    logic         trial_valid;
    logic         busy;
    logic         done;
    logic         exact;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    signed_sar_search #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .trial       (trial),
        .trial_valid (trial_valid),
        .cmp_valid   (cmp_valid),
        .cmp_gt      (cmp_gt),
        .cmp_lt      (cmp_lt),
        .cmp_eq      (cmp_eq),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .exact       (exact)
    );

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Comparator model. tgt2 is twice the target so half-integer targets are expressible.
    // mode 0: true comparison, 1: always gt, 2: always lt, 3: no flag asserted.
    task automatic run_search(input int tgt2, input int mode, input int dly, input bit pulse_start,
                              output int tr[8], output int n, output bit stable, output bit done_ok);
        int cur;
        for (int j = 0; j < 8; j++) tr[j] = 99;
        n = 0;
        stable = 1'b1;
        done_ok = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (n < 8) begin
            cur = int'($signed(trial));
            if (!trial_valid || !busy) stable = 1'b0;
            repeat (dly) begin
                if (pulse_start) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                if (int'($signed(trial)) != cur || !trial_valid || !busy || done) stable = 1'b0;
            end
            tr[n] = cur;
            cmp_valid = 1'b1;
            case (mode)
                0: begin
                    if (tgt2 == cur * 2)     cmp_eq = 1'b1;
                    else if (tgt2 > cur * 2) cmp_gt = 1'b1;
                    else                     cmp_lt = 1'b1;
                end
                1: cmp_gt = 1'b1;
                2: cmp_lt = 1'b1;
                default: ;
            endcase
            @(negedge clk);
            cmp_valid = 1'b0; cmp_gt = 1'b0; cmp_lt = 1'b0; cmp_eq = 1'b0;
            n++;
            if (done) begin
                done_ok = !busy && !trial_valid;
                break;
            end
            if (!busy) break;
        end
        @(negedge clk);
        if (done || busy) done_ok = 1'b0;
    endtask

    task automatic test_search(input string name, input int tgt2, input int mode, input int dly,
                               input bit pulse_start, input int exp_t[4], input int exp_res,
                               input bit exp_exact);
        int tr[8];
        int n;
        bit stable;
        bit done_ok;
        run_search(tgt2, mode, dly, pulse_start, tr, n, stable, done_ok);
        total++;
        if (n !== 4) $display("FAIL %s responses: got %0d want 4", name, n);
        else passed++;
        for (int j = 0; j < 4; j++) begin
            total++;
            if (tr[j] !== exp_t[j]) $display("FAIL %s trial[%0d]: got %0d want %0d", name, j, tr[j], exp_t[j]);
            else passed++;
        end
        total++;
        if (int'($signed(result)) !== exp_res)
            $display("FAIL %s result: got %0d want %0d", name, int'($signed(result)), exp_res);
        else passed++;
        total++;
        if (exact !== exp_exact) $display("FAIL %s exact: got %0b want %0b", name, exact, exp_exact);
        else passed++;
        total++;
        if (stable !== 1'b1) $display("FAIL %s trial_stable: got %0b want 1", name, stable);
        else passed++;
        total++;
        if (done_ok !== 1'b1) $display("FAIL %s done_pulse: got %0b want 1", name, done_ok);
        else passed++;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({trial, trial_valid, busy, done, result, exact} !== {4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0})
            $display("FAIL reset_state: got trial=%0d tv=%0b busy=%0b done=%0b result=%0d exact=%0b want all 0",
                     trial, trial_valid, busy, done, result, exact);
        else passed++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, trial_valid} !== 3'b000)
            $display("FAIL reset_idle: got busy=%0b done=%0b tv=%0b want 000", busy, done, trial_valid);
        else passed++;
    endtask

    task automatic test_idle_ignore();
        int held;
        bit bad;
        held = int'($signed(result));
        bad = 1'b0;
        cmp_valid = 1'b1; cmp_eq = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (busy || done || trial_valid || int'($signed(result)) != held) bad = 1'b1;
        end
        cmp_valid = 1'b0; cmp_eq = 1'b0;
        total++;
        if (bad !== 1'b0) $display("FAIL idle_cmp_ignored: got disturbed=%0b want 0", bad);
        else passed++;
        total++;
        if (int'($signed(result)) !== -8) $display("FAIL result_hold: got %0d want -8", int'($signed(result)));
        else passed++;
    endtask

    task automatic test_reset_mid();
        int e[4];
        bit bad;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) begin
            cmp_valid = 1'b1; cmp_gt = 1'b1;
            @(negedge clk);
            cmp_valid = 1'b0; cmp_gt = 1'b0;
        end
        total++;
        if (int'($signed(trial)) !== 6 || busy !== 1'b1)
            $display("FAIL mid_trial: got trial=%0d busy=%0b want trial=6 busy=1", int'($signed(trial)), busy);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({trial, trial_valid, busy, done, result, exact} !== {4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0})
            $display("FAIL mid_reset_state: got trial=%0d tv=%0b busy=%0b done=%0b result=%0d exact=%0b want all 0",
                     trial, trial_valid, busy, done, result, exact);
        else passed++;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) bad = 1'b1;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done || busy) bad = 1'b1;
        end
        total++;
        if (bad !== 1'b0) $display("FAIL mid_reset_no_done: got done/busy seen=%0b want 0", bad);
        else passed++;
        // -8 is never presented as a trial; it is reached by saturating below -7.
        e = '{0, -4, -6, -7};
        test_search("after_reset_m8", -16, 0, 1, 1'b0, e, -8, 1'b0);
    endtask

    initial begin
        int e[4];
        test_reset();
        e = '{0, 4, 6, 5};
        test_search("target_5", 10, 0, 0, 1'b0, e, 5, 1'b1);
        e = '{0, -4, -2, -3};
        test_search("target_m3", -6, 0, 1, 1'b0, e, -3, 1'b1);
        e = '{0, 4, 2, 3};
        test_search("target_2p5", 5, 0, 2, 1'b0, e, 2, 1'b0);
        e = '{0, 4, 6, 7};
        test_search("always_gt", 0, 1, 0, 1'b0, e, 7, 1'b0);
        e = '{0, -4, -6, -7};
        test_search("always_lt", 0, 2, 0, 1'b0, e, -8, 1'b0);
        test_idle_ignore();
        e = '{0, -4, -6, -7};
        test_search("none_flag", 0, 3, 1, 1'b0, e, -8, 1'b0);
        e = '{0, 4, 6, 5};
        test_search("stall_start", 10, 0, 3, 1'b1, e, 5, 1'b1);
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
